aes_iter_sequencer: RTL

//  Iterative AES-128 encryption controller. Accepts a block and key over a

---
 rtl/aes_pkg.sv | 22 ++
 rtl/aes_iter_sequencer.sv | 119 +++++++++++
 2 files changed

// File: rtl/aes_pkg.sv
// Shared types, constants and helpers for the iterative AES-128 encrypt path.
// The round unit and key-expansion step import this alongside the sequencer.
package aes_pkg;

    typedef logic [127:0] block_t;
    typedef logic [7:0]   byte_t;

    localparam int    AES128_NR = 10;
    localparam byte_t RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } seq_state_t;

    // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/aes_iter_sequencer.sv
// Iterative AES-128 encryption controller: one round per clock through an
// external combinational round unit and key-expansion step.
module aes_iter_sequencer
    import aes_pkg::*;
#(
    parameter int NR    = 10,
    parameter int BLK_W = 128
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BLK_W-1:0] in_text,
    input  logic [BLK_W-1:0] in_key,

    output logic             out_valid,
    input  logic             out_ready,
    output logic [BLK_W-1:0] out_text,

    input  logic             abort,
    output logic             busy,

    output logic [BLK_W-1:0] ks_prev_key,
    output logic [7:0]       ks_rcon,
    input  logic [BLK_W-1:0] ks_next_key,

    output logic [BLK_W-1:0] rd_state,
    output logic [BLK_W-1:0] rd_key,
    output logic             rd_final,
    input  logic [BLK_W-1:0] rd_result
);

    // Only the AES-128 schedule is implemented; anything else must not build.
    if (NR != AES128_NR || BLK_W != 128) begin : g_bad_cfg
        $fatal(1, "aes_iter_sequencer: only NR=10, BLK_W=128 supported");
    end

    localparam logic [3:0] LAST_ROUND = 4'(AES128_NR);

    seq_state_t fsm_q,   fsm_d;
    block_t     state_q, state_d;
    block_t     key_q,   key_d;
    logic [3:0] round_q, round_d;
    byte_t      rcon_q,  rcon_d;

    logic       load;

    assign in_ready  = (fsm_q == IDLE) | ((fsm_q == DONE) & out_ready);
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN);
    assign out_text  = state_q;

    // Datapath drives are unconditional; the round logic ignores them outside RUN.
    assign rd_state    = state_q;
    assign ks_prev_key = key_q;
    assign ks_rcon     = rcon_q;
    assign rd_key      = ks_next_key;
    assign rd_final    = (round_q == LAST_ROUND);

    // Abort wins over a simultaneous accept, so the block is never half-loaded.
    assign load = in_valid & in_ready & ~abort;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        rcon_d  = rcon_q;

        if (abort) begin
            fsm_d = IDLE;
        end else if (load) begin
            state_d = in_text ^ in_key;
            key_d   = in_key;
            round_d = 4'd1;
            rcon_d  = RCON_INIT;
            fsm_d   = RUN;
        end else begin
            case (fsm_q)
                RUN: begin
                    state_d = rd_result;
                    key_d   = ks_next_key;
                    rcon_d  = xtime(rcon_q);
                    if (round_q == LAST_ROUND) begin
                        fsm_d = DONE;
                    end else begin
                        round_d = round_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_d = IDLE;
                    end
                end
                default: begin
                    fsm_d = fsm_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
            rcon_q  <= RCON_INIT;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

endmodule
